// File: rtl/conv_read_addr_gen_pkg.sv
// Shared encodings and sizing helpers for the CNN register-file address generators.
package conv_addr_pkg;

  typedef enum logic {
    MODE_SEQ = 1'b0,
    MODE_WIN = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of window positions along one axis.
  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  // Width of a counter that counts 0..max-1 (at least one bit).
  function automatic int cnt_w(input int max);
    return (max > 1) ? $clog2(max) : 1;
  endfunction

endpackage

// File: rtl/conv_read_addr_gen_if.sv
// Control and read-port bundle between layer controller, address generator and register file.
interface conv_read_addr_gen_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] base_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              win_last;
  logic              busy;
  logic              done;

  // Driver side: controller plus register-file ready.
  modport master (
    output start, mode, base_addr, rd_ready,
    input  rd_valid, rd_addr, win_last, busy, done
  );

  // Address generator side.
  modport slave (
    input  start, mode, base_addr, rd_ready,
    output rd_valid, rd_addr, win_last, busy, done
  );
endinterface

// File: rtl/conv_read_addr_gen_wrap_counter.sv
// Modulo-MAX counter used as one stage of the window index chain.
module wrap_counter
  import conv_addr_pkg::*;
#(
  parameter int MAX = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  output logic [cnt_w(MAX)-1:0]  count,
  output logic                   last
);
  localparam int W = cnt_w(MAX);

  logic [W-1:0] count_q;

  assign count = count_q;
  assign last  = (count_q == W'(MAX - 1));

  // Advance on enable and wrap after MAX-1; clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= last ? '0 : count_q + W'(1);
    end
  end
endmodule

// File: rtl/conv_read_addr_gen.sv
// Read-address generator: sequential sweep or KxK sliding-window taps, valid/ready output.
module conv_read_addr_gen
  import conv_addr_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 15,
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 3,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  conv_read_addr_gen_if.slave bus
);
  localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H = out_dim(IMG_H, K, STRIDE);
  localparam int SUM_W = ADDR_W + $clog2(IMG_W * IMG_H) + 1;
  localparam int KC_W  = cnt_w(DEPTH);
  localparam int KR_W  = cnt_w(K);
  localparam int OC_W  = cnt_w(OUT_W);
  localparam int OR_W  = cnt_w(OUT_H);

  if (IMG_W * IMG_H > DEPTH) begin : g_chk_area
    $error("feature map does not fit in DEPTH entries");
  end
  if (K > IMG_W || K > IMG_H) begin : g_chk_kernel
    $error("kernel larger than feature map");
  end
  if (STRIDE < 1) begin : g_chk_stride
    $error("STRIDE must be at least 1");
  end
  if (DEPTH > 2 ** ADDR_W) begin : g_chk_depth
    $error("DEPTH exceeds ADDR_W address space");
  end

  state_e            state_q;
  mode_e             mode_q;
  logic [ADDR_W-1:0] base_q, rd_addr_q, addr_d;
  logic              rd_valid_q, win_last_q, busy_q, done_q, win_last_d;

  // Counters hold the index of the tap currently presented on rd_addr.
  logic [KC_W-1:0]  kc_q, nxt_kc;
  logic [KR_W-1:0]  kr_q, nxt_kr;
  logic [OC_W-1:0]  oc_q, nxt_oc;
  logic [OR_W-1:0]  or_q, nxt_or;
  logic             kc_last, kr_last, oc_last, or_last;
  logic             win, adv, clr_all, kc_wl, kr_en, oc_en, or_en, final_hs;
  logic [SUM_W-1:0] sum;

  assign win      = (mode_q == MODE_WIN);
  assign adv      = rd_valid_q && bus.rd_ready;
  assign clr_all  = (state_q == ST_IDLE) && bus.start;
  assign kc_wl    = (kc_q == KC_W'(K - 1));
  assign kr_en    = adv && win && kc_wl;
  assign oc_en    = kr_en && kr_last;
  assign or_en    = oc_en && oc_last;
  assign final_hs = win ? (kc_wl && kr_last && oc_last && or_last) : kc_last;

  // kc doubles as the SEQ index, so it is sized for DEPTH and cut short at K in WIN mode.
  wrap_counter #(.MAX(DEPTH)) u_kc (
    .clk(clk), .rst_n(rst_n), .en(adv), .clr(clr_all || kr_en),
    .count(kc_q), .last(kc_last)
  );
  wrap_counter #(.MAX(K)) u_kr (
    .clk(clk), .rst_n(rst_n), .en(kr_en), .clr(clr_all),
    .count(kr_q), .last(kr_last)
  );
  wrap_counter #(.MAX(OUT_W)) u_oc (
    .clk(clk), .rst_n(rst_n), .en(oc_en), .clr(clr_all),
    .count(oc_q), .last(oc_last)
  );
  wrap_counter #(.MAX(OUT_H)) u_or (
    .clk(clk), .rst_n(rst_n), .en(or_en), .clr(clr_all),
    .count(or_q), .last(or_last)
  );

  // Address of the tap that follows the current one, so it can be registered on handshake.
  always_comb begin
    nxt_kc = (win && kc_wl) ? '0 : kc_q + KC_W'(1);
    nxt_kr = kc_wl ? (kr_last ? '0 : kr_q + KR_W'(1)) : kr_q;
    nxt_oc = (kc_wl && kr_last) ? (oc_last ? '0 : oc_q + OC_W'(1)) : oc_q;
    nxt_or = (kc_wl && kr_last && oc_last) ? or_q + OR_W'(1) : or_q;
    if (win) begin
      sum = SUM_W'(base_q)
          + (SUM_W'(nxt_or) * SUM_W'(STRIDE) + SUM_W'(nxt_kr)) * SUM_W'(IMG_W)
          + SUM_W'(nxt_oc) * SUM_W'(STRIDE) + SUM_W'(nxt_kc);
    end else begin
      sum = SUM_W'(base_q) + SUM_W'(nxt_kc);
    end
    addr_d     = ADDR_W'(sum % SUM_W'(DEPTH));
    win_last_d = win && (nxt_kc == KC_W'(K - 1)) && (nxt_kr == KR_W'(K - 1));
  end

  // Control FSM with registered outputs; the first address is the base itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_SEQ;
      base_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      win_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q    <= ST_RUN;
            mode_q     <= mode_e'(bus.mode);
            base_q     <= bus.base_addr;
            rd_valid_q <= 1'b1;
            rd_addr_q  <= bus.base_addr;
            win_last_q <= bus.mode && (K == 1);
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (adv) begin
            if (final_hs) begin
              state_q    <= ST_DONE;
              rd_valid_q <= 1'b0;
              rd_addr_q  <= '0;
              win_last_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              rd_addr_q  <= addr_d;
              win_last_q <= win_last_d;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.win_last = win_last_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule
